// File: rtl/laser_pkg.sv
// Shared constants, FSM state type, point type and the squared-distance helper for the
// laser coverage host.
package laser_pkg;

  localparam int unsigned LASER_NPTS    = 40;
  localparam int unsigned LASER_R2      = 16;
  localparam int unsigned LASER_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StStream,
    StWaitLow,
    StWaitDone,
    StScore,
    StReport
  } state_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } point_t;

  function automatic logic [8:0] dist2(input point_t p, input point_t c);
    logic [3:0] dx, dy;
    logic [7:0] dx2, dy2;
    dx  = (p.x >= c.x) ? p.x - c.x : c.x - p.x;
    dy  = (p.y >= c.y) ? p.y - c.y : c.y - p.y;
    dx2 = dx * dx;
    dy2 = dy * dy;
    return 9'(dx2) + 9'(dy2);
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational coverage test: is a point inside either of two radius-sqrt(R2) circles.
module laser_cover_chk
  import laser_pkg::*;
#(
  parameter int unsigned R2 = LASER_R2
) (
  input  point_t pt_i,
  input  point_t c1_i,
  input  point_t c2_i,
  output logic   covered_o
);

  always_comb begin
    covered_o = (dist2(pt_i, c1_i) <= 9'(R2)) || (dist2(pt_i, c2_i) <= 9'(R2));
  end

endmodule

// File: rtl/laser_host.sv
// Host driver: buffers a point set, streams it to the coverage engine on its DONE-framed bus,
// captures the two returned centres and scores how many points they cover.
module laser_host
  import laser_pkg::*;
#(
  parameter int unsigned NPTS    = LASER_NPTS,
  parameter int unsigned R2      = LASER_R2,
  parameter int unsigned TIMEOUT = LASER_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [3:0] ld_x,
  input  logic [3:0] ld_y,
  input  logic       start,
  output logic       busy,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       res_valid,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic [5:0] res_cover,
  output logic       res_err
);

  localparam int unsigned IdxW = $clog2(NPTS);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  point_t            pbuf_q [NPTS];
  logic [IdxW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_nxt;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [3:0]        x_q, x_d, y_q, y_d;
  point_t            res_c1_q, res_c1_d, res_c2_q, res_c2_d;
  logic [5:0]        res_cover_q, res_cover_d;
  logic              res_err_q, res_err_d;
  logic              ld_we;
  logic              covered;
  logic              tmo_hit;

  laser_cover_chk #(
    .R2(R2)
  ) u_cover_chk (
    .pt_i     (pbuf_q[idx_q]),
    .c1_i     (res_c1_q),
    .c2_i     (res_c2_q),
    .covered_o(covered)
  );

  assign idx_nxt = idx_q + 1'b1;
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    x_d         = '0;
    y_d         = '0;
    res_c1_d    = res_c1_q;
    res_c2_d    = res_c2_q;
    res_cover_d = res_cover_q;
    res_err_d   = res_err_q;
    ld_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_valid) begin
          ld_we    = 1'b1;
          wr_ptr_d = (wr_ptr_q == IdxW'(NPTS - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        // start overrides the pointer advance so the next load set begins at slot 0
        if (start) begin
          wr_ptr_d  = '0;
          res_err_d = 1'b0;
          state_d   = StArmed;
        end
      end
      StArmed: begin
        if (DONE) begin
          idx_d   = '0;
          x_d     = pbuf_q[0].x;
          y_d     = pbuf_q[0].y;
          state_d = StStream;
        end
      end
      StStream: begin
        if (idx_q == IdxW'(NPTS - 1)) begin
          tmo_d   = '0;
          state_d = StWaitLow;
        end else begin
          idx_d = idx_nxt;
          x_d   = pbuf_q[idx_nxt].x;
          y_d   = pbuf_q[idx_nxt].y;
        end
      end
      StWaitLow: begin
        if (tmo_hit) begin
          res_err_d   = 1'b1;
          res_cover_d = '0;
          state_d     = StReport;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (!DONE) state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (DONE) begin
          res_c1_d = '{x: C1X, y: C1Y};
          res_c2_d = '{x: C2X, y: C2Y};
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = StScore;
        end else if (tmo_hit) begin
          res_err_d   = 1'b1;
          res_cover_d = '0;
          state_d     = StReport;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StScore: begin
        cnt_d = cnt_q + 6'(covered);
        if (idx_q == IdxW'(NPTS - 1)) begin
          res_cover_d = cnt_d;
          state_d     = StReport;
        end else begin
          idx_d = idx_nxt;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_c1_q    <= '0;
      res_c2_q    <= '0;
      res_cover_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_c1_q    <= res_c1_d;
      res_c2_q    <= res_c2_d;
      res_cover_q <= res_cover_d;
      res_err_q   <= res_err_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NPTS; i++) pbuf_q[i] <= '0;
    end else if (ld_we) begin
      pbuf_q[wr_ptr_q] <= '{x: ld_x, y: ld_y};
    end
  end

  assign ld_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StReport);
  assign X         = x_q;
  assign Y         = y_q;
  assign res_c1x   = res_c1_q.x;
  assign res_c1y   = res_c1_q.y;
  assign res_c2x   = res_c2_q.x;
  assign res_c2y   = res_c2_q.y;
  assign res_cover = res_cover_q;
  assign res_err   = res_err_q;

endmodule
